// File: rtl/compile_guard_handshake_monitor.sv
// Passive valid/ready protocol monitor for N channels: sticky stability/timeout flags,
// saturating transfer counters and a first-error record. Collapses to constant 0 without ASSERT_ON.
module compile_guard_handshake_monitor #(
  parameter int N          = 2,
  parameter int WIDTH      = 8,
  parameter int MAX_STALL  = 16,
  parameter int CNT_W      = 8,
  parameter int CHECK_DATA = 1,
  parameter int REPORT     = 0
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [N-1:0]                        valid,
  input  logic [N-1:0]                        ready,
  input  logic [N*WIDTH-1:0]                  data,
  input  logic                                clear,
  output logic [N-1:0]                        err_stable,
  output logic [N-1:0]                        err_timeout,
  output logic                                any_err,
  output logic                                first_err_vld,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] first_err_ch,
  output logic [N*CNT_W-1:0]                  xfer_count
);

  localparam int CH_W = (N > 1) ? $clog2(N) : 1;
  // REPORT is accepted at this level; message reporting lives in simulation-only wrappers.
  localparam int cfg_unused = REPORT;

`ifdef ASSERT_ON

  localparam int SCNT_W      = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam int SCNT_LAST_I = (MAX_STALL > 0) ? MAX_STALL - 1 : 0;
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(MAX_STALL);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCNT_LAST_I);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [N-1:0]    stall;
  logic [N-1:0]    stab_evt;
  logic [N-1:0]    to_evt;
  logic [N-1:0]    err_stable_vec;
  logic [N-1:0]    err_timeout_vec;
  logic            first_err_vld_reg;
  logic [CH_W-1:0] first_err_ch_reg;
  logic [CH_W-1:0] first_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [WIDTH-1:0]  data_ch;
      logic [WIDTH-1:0]  data_q_reg;
      logic              stall_q_reg;
      logic [SCNT_W-1:0] scnt_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic              err_stable_reg;
      logic              err_timeout_reg;
      logic              xfer;
      logic              data_diff;

      assign data_ch      = data[gi*WIDTH +: WIDTH];
      assign stall[gi]    = valid[gi] & ~ready[gi];
      assign xfer         = valid[gi] & ready[gi];
      assign data_diff    = (CHECK_DATA != 0) && (data_ch != data_q_reg);
      // The cycle after any stall (including the releasing transfer) must still present the held beat.
      assign stab_evt[gi] = stall_q_reg & (~valid[gi] | data_diff);
      assign to_evt[gi]   = (MAX_STALL > 0) && stall[gi] && (scnt_reg == SCNT_LAST) && !err_timeout_reg;

      always_ff @(posedge CLK) begin
        if (RESET || clear) begin
          data_q_reg      <= '0;
          stall_q_reg     <= 1'b0;
          scnt_reg        <= '0;
          cnt_reg         <= '0;
          err_stable_reg  <= 1'b0;
          err_timeout_reg <= 1'b0;
        end else begin
          stall_q_reg <= stall[gi];
          if (stall[gi] && !stall_q_reg)
            data_q_reg <= data_ch;
          if (!stall[gi])
            scnt_reg <= '0;
          else if (scnt_reg != SCNT_MAX)
            scnt_reg <= scnt_reg + 1'b1;
          if (xfer && (cnt_reg != CNT_MAX))
            cnt_reg <= cnt_reg + 1'b1;
          if (stab_evt[gi])
            err_stable_reg <= 1'b1;
          if (to_evt[gi])
            err_timeout_reg <= 1'b1;
        end
      end

      assign err_stable_vec[gi]               = err_stable_reg;
      assign err_timeout_vec[gi]              = err_timeout_reg;
      assign xfer_count[gi*CNT_W +: CNT_W]    = cnt_reg;
    end
  endgenerate

  // Lowest channel with a fresh event wins when several fire together.
  always_comb begin
    first_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (stab_evt[i] || to_evt[i])
        first_idx = CH_W'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      first_err_vld_reg <= 1'b0;
      first_err_ch_reg  <= '0;
    end else if (!first_err_vld_reg && (|(stab_evt | to_evt))) begin
      first_err_vld_reg <= 1'b1;
      first_err_ch_reg  <= first_idx;
    end
  end

  assign err_stable    = err_stable_vec;
  assign err_timeout   = err_timeout_vec;
  assign any_err       = (|err_stable_vec) | (|err_timeout_vec);
  assign first_err_vld = first_err_vld_reg;
  assign first_err_ch  = first_err_ch_reg;

`else

  logic inputs_unused;
  assign inputs_unused = ^{CLK, RESET, valid, ready, data, clear};

  assign err_stable    = '0;
  assign err_timeout   = '0;
  assign any_err       = 1'b0;
  assign first_err_vld = 1'b0;
  assign first_err_ch  = '0;
  assign xfer_count    = '0;

`endif

endmodule

// File: tb/tb_compile_guard_handshake_monitor.sv
// Directed bench for the handshake monitor (N=2, WIDTH=8, MAX_STALL=4, CNT_W=4).
// Expectations fold to zero when the monitor is compiled out.
module tb_compile_guard_handshake_monitor;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [15:0] data;
  logic        clear;
  logic [1:0]  err_stable;
  logic [1:0]  err_timeout;
  logic        any_err;
  logic        first_err_vld;
  logic [0:0]  first_err_ch;
  logic [7:0]  xfer_count;

  int tests_run = 0;
  int tests_failed = 0;

  compile_guard_handshake_monitor #(
    .N(2), .WIDTH(8), .MAX_STALL(4), .CNT_W(4), .CHECK_DATA(1), .REPORT(0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .valid(valid), .ready(ready), .data(data), .clear(clear),
    .err_stable(err_stable), .err_timeout(err_timeout), .any_err(any_err),
    .first_err_vld(first_err_vld), .first_err_ch(first_err_ch), .xfer_count(xfer_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ex(input logic [31:0] v);
`ifdef ASSERT_ON
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs then reflect the inputs of the cycle just sampled.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] r, input logic [7:0] d0, input logic [7:0] d1);
    valid = v;
    ready = r;
    data  = {d1, d0};
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flags"}, {28'd0, err_stable, err_timeout}, 32'd0);
    check({tag, ".first"}, {30'd0, first_err_vld, first_err_ch}, 32'd0);
    check({tag, ".count"}, {24'd0, xfer_count}, 32'd0);
    check({tag, ".any"}, {31'd0, any_err}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    clear = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    step();
    step();
    check_all_zero("reset");
    RESET = 1'b0;

    // 1: continuous transfers on ch0 saturate at 15
    drive(2'b01, 2'b01, 8'h10, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1)  check("t1.count_k1",  {24'd0, xfer_count}, ex(32'h01));
      if (k == 14) check("t1.count_k14", {24'd0, xfer_count}, ex(32'h0E));
      if (k == 15) check("t1.count_k15", {24'd0, xfer_count}, ex(32'h0F));
    end
    check("t1.count_sat", {24'd0, xfer_count}, ex(32'h0F));
    check("t1.flags", {28'd0, err_stable, err_timeout}, 32'd0);
    check("t1.any", {31'd0, any_err}, 32'd0);
    do_reset();
    check("t1.count_after_reset", {24'd0, xfer_count}, 32'd0);

    // 2: legal 3-cycle stall on ch1 then transfer
    drive(2'b10, 2'b00, 8'h00, 8'hA5);
    repeat (3) step();
    drive(2'b10, 2'b10, 8'h00, 8'hA5);
    step();
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    step();
    check("t2.count", {24'd0, xfer_count}, ex(32'h10));
    check("t2.flags", {28'd0, err_stable, err_timeout}, 32'd0);
    check("t2.first_vld", {31'd0, first_err_vld}, 32'd0);
    do_reset();

    // 3: ch1 data changes on stall cycle 2
    drive(2'b10, 2'b00, 8'h00, 8'hA5);
    step();
    check("t3.stable_before", {30'd0, err_stable}, 32'd0);
    drive(2'b10, 2'b00, 8'h00, 8'h5A);
    step();
    check("t3.stable", {30'd0, err_stable}, ex(32'h2));
    check("t3.first_vld", {31'd0, first_err_vld}, ex(32'h1));
    check("t3.first_ch", {31'd0, first_err_ch}, ex(32'h1));
    check("t3.any", {31'd0, any_err}, ex(32'h1));
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    step();
    check("t3.sticky", {30'd0, err_stable}, ex(32'h2));
    do_reset();

    // 4a: ch0 stalls 4 cycles -> timeout visible after the 4th
    drive(2'b01, 2'b00, 8'h11, 8'h00);
    repeat (3) step();
    check("t4.timeout_c3", {30'd0, err_timeout}, 32'd0);
    step();
    check("t4.timeout_c4", {30'd0, err_timeout}, ex(32'h1));
    check("t4.first_ch", {31'd0, first_err_ch}, 32'd0);
    check("t4.first_vld", {31'd0, first_err_vld}, ex(32'h1));
    step();
    drive(2'b01, 2'b01, 8'h11, 8'h00);
    step();
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    step();
    check("t4.timeout_hold", {30'd0, err_timeout}, ex(32'h1));
    check("t4.stable_none", {30'd0, err_stable}, 32'd0);
    check("t4.count", {24'd0, xfer_count}, ex(32'h01));
    do_reset();

    // 4b: stall 3, transfer, stall 3, transfer -> stall count restarts, no timeout
    for (int rep = 0; rep < 2; rep++) begin
      drive(2'b01, 2'b00, 8'h22, 8'h00);
      repeat (3) step();
      drive(2'b01, 2'b01, 8'h22, 8'h00);
      step();
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    step();
    check("t4b.timeout", {30'd0, err_timeout}, 32'd0);
    check("t4b.count", {24'd0, xfer_count}, ex(32'h02));
    check("t4b.any", {31'd0, any_err}, 32'd0);
    do_reset();

    // 5: both channels drop valid mid-stall together, then clear
    drive(2'b11, 2'b00, 8'h33, 8'h44);
    repeat (2) step();
    drive(2'b00, 2'b00, 8'h33, 8'h44);
    step();
    check("t5.stable", {30'd0, err_stable}, ex(32'h3));
    check("t5.first_ch", {31'd0, first_err_ch}, 32'd0);
    check("t5.first_vld", {31'd0, first_err_vld}, ex(32'h1));
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_all_zero("t5.clear");

    // 5b: violation coincident with clear is discarded
    drive(2'b11, 2'b00, 8'h55, 8'h66);
    step();
    drive(2'b00, 2'b00, 8'h55, 8'h66);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    check("t5b.stable", {30'd0, err_stable}, 32'd0);
    check("t5b.first_vld", {31'd0, first_err_vld}, 32'd0);
    do_reset();

    // 6: RESET mid-stall restarts the stall count
    drive(2'b01, 2'b00, 8'h77, 8'h00);
    repeat (3) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    repeat (3) step();
    check("t6.timeout_after3", {30'd0, err_timeout}, 32'd0);
    step();
    check("t6.timeout_after4", {30'd0, err_timeout}, ex(32'h1));
    check("t6.first_ch", {31'd0, first_err_ch}, 32'd0);
    drive(2'b00, 2'b00, 8'h00, 8'h00);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
